// File: rtl/usrp_tag_tx_scheduler_pkg.sv
// Shared definitions for the tag-chip transmit scheduler: state and register
// encodings plus the power-on schedule.
package usrp_tag_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_PREAMBLE = 3'd3,
    ST_GAP      = 3'd4,
    ST_TX       = 3'd5
  } sched_state_e;

  typedef enum logic [2:0] {
    REG_SETTLE     = 3'd0,
    REG_PRMB_NBITS = 3'd1,
    REG_PRMB_OS    = 3'd2,
    REG_GAP        = 3'd3,
    REG_NFRAMES    = 3'd4,
    REG_CTRL       = 3'd5
  } sched_reg_e;

  localparam int unsigned SCHED_DEF_SETTLE     = 32;
  localparam int unsigned SCHED_DEF_PRMB_NBITS = 2046;
  localparam int unsigned SCHED_DEF_PRMB_OS    = 256;
  localparam int unsigned SCHED_DEF_GAP        = 32768;
  localparam int unsigned SCHED_DEF_NFRAMES    = 1;

endpackage

// File: rtl/usrp_tag_tx_scheduler_if.sv
// Host settings bus feeding the scheduler's configuration registers.
interface usrp_tag_tx_scheduler_if;
  logic        cfg_wr;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_data;

  modport master (output cfg_wr, output cfg_addr, output cfg_data);
  modport slave  (input  cfg_wr, input  cfg_addr, input  cfg_data);
endinterface

// File: rtl/usrp_tag_tx_scheduler_regs.sv
// Settings-bus decode, live configuration registers and the per-frame shadow
// copy that the sequencer actually runs from.
module usrp_tag_sched_regs
  import usrp_tag_sched_pkg::*;
#(
  parameter int unsigned CNT_WIDTH      = 24,
  parameter int unsigned NBITS_WIDTH    = 12,
  parameter int unsigned FRAME_WIDTH    = 16,
  parameter int unsigned DEF_SETTLE     = SCHED_DEF_SETTLE,
  parameter int unsigned DEF_PRMB_NBITS = SCHED_DEF_PRMB_NBITS,
  parameter int unsigned DEF_PRMB_OS    = SCHED_DEF_PRMB_OS,
  parameter int unsigned DEF_GAP        = SCHED_DEF_GAP
) (
  input  logic                   clk,
  input  logic                   reset,
  usrp_tag_tx_scheduler_if.slave cfg,
  input  logic                   shadow_ld,
  output logic                   trig_en_live,
  output logic [CNT_WIDTH-1:0]   sh_settle,
  output logic [NBITS_WIDTH-1:0] sh_nbits,
  output logic [CNT_WIDTH-1:0]   sh_os,
  output logic [CNT_WIDTH-1:0]   sh_gap,
  output logic [FRAME_WIDTH-1:0] sh_nframes,
  output logic                   sh_trig_en
);

  logic [CNT_WIDTH-1:0]   settle_q, settle_d;
  logic [NBITS_WIDTH-1:0] nbits_q, nbits_d;
  logic [CNT_WIDTH-1:0]   os_q, os_d;
  logic [CNT_WIDTH-1:0]   gap_q, gap_d;
  logic [FRAME_WIDTH-1:0] nframes_q, nframes_d;
  logic                   trig_en_q, trig_en_d;

  logic [CNT_WIDTH-1:0]   sh_settle_q, sh_settle_d;
  logic [NBITS_WIDTH-1:0] sh_nbits_q, sh_nbits_d;
  logic [CNT_WIDTH-1:0]   sh_os_q, sh_os_d;
  logic [CNT_WIDTH-1:0]   sh_gap_q, sh_gap_d;
  logic [FRAME_WIDTH-1:0] sh_nframes_q, sh_nframes_d;
  logic                   sh_trig_en_q, sh_trig_en_d;

  // Data bits above each register's width are don't-care.
  logic unused_cfg_bits;
  assign unused_cfg_bits = ^(cfg.cfg_data >> CNT_WIDTH);

  always_comb begin
    settle_d  = settle_q;
    nbits_d   = nbits_q;
    os_d      = os_q;
    gap_d     = gap_q;
    nframes_d = nframes_q;
    trig_en_d = trig_en_q;
    if (cfg.cfg_wr) begin
      case (cfg.cfg_addr)
        REG_SETTLE:     settle_d  = cfg.cfg_data[CNT_WIDTH-1:0];
        REG_PRMB_NBITS: nbits_d   = cfg.cfg_data[NBITS_WIDTH-1:0];
        REG_PRMB_OS:    os_d      = cfg.cfg_data[CNT_WIDTH-1:0];
        REG_GAP:        gap_d     = cfg.cfg_data[CNT_WIDTH-1:0];
        REG_NFRAMES:    nframes_d = cfg.cfg_data[FRAME_WIDTH-1:0];
        REG_CTRL:       trig_en_d = cfg.cfg_data[0];
        default: ;
      endcase
    end
  end

  // Shadows sample the pre-write live value when a write coincides with a latch.
  always_comb begin
    sh_settle_d  = shadow_ld ? settle_q  : sh_settle_q;
    sh_nbits_d   = shadow_ld ? nbits_q   : sh_nbits_q;
    sh_os_d      = shadow_ld ? os_q      : sh_os_q;
    sh_gap_d     = shadow_ld ? gap_q     : sh_gap_q;
    sh_nframes_d = shadow_ld ? nframes_q : sh_nframes_q;
    sh_trig_en_d = shadow_ld ? trig_en_q : sh_trig_en_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      settle_q     <= CNT_WIDTH'(DEF_SETTLE);
      nbits_q      <= NBITS_WIDTH'(DEF_PRMB_NBITS);
      os_q         <= CNT_WIDTH'(DEF_PRMB_OS);
      gap_q        <= CNT_WIDTH'(DEF_GAP);
      nframes_q    <= FRAME_WIDTH'(SCHED_DEF_NFRAMES);
      trig_en_q    <= 1'b0;
      sh_settle_q  <= CNT_WIDTH'(DEF_SETTLE);
      sh_nbits_q   <= NBITS_WIDTH'(DEF_PRMB_NBITS);
      sh_os_q      <= CNT_WIDTH'(DEF_PRMB_OS);
      sh_gap_q     <= CNT_WIDTH'(DEF_GAP);
      sh_nframes_q <= FRAME_WIDTH'(SCHED_DEF_NFRAMES);
      sh_trig_en_q <= 1'b0;
    end else begin
      settle_q     <= settle_d;
      nbits_q      <= nbits_d;
      os_q         <= os_d;
      gap_q        <= gap_d;
      nframes_q    <= nframes_d;
      trig_en_q    <= trig_en_d;
      sh_settle_q  <= sh_settle_d;
      sh_nbits_q   <= sh_nbits_d;
      sh_os_q      <= sh_os_d;
      sh_gap_q     <= sh_gap_d;
      sh_nframes_q <= sh_nframes_d;
      sh_trig_en_q <= sh_trig_en_d;
    end
  end

  assign trig_en_live = trig_en_q;
  assign sh_settle    = sh_settle_q;
  assign sh_nbits     = sh_nbits_q;
  assign sh_os        = sh_os_q;
  assign sh_gap       = sh_gap_q;
  assign sh_nframes   = sh_nframes_q;
  assign sh_trig_en   = sh_trig_en_q;

endmodule

// File: rtl/usrp_tag_tx_scheduler.sv
// Frame sequencer for the tag-chip transmit path: settle, BPSK preamble, gap,
// then a localization burst, repeated per the programmed frame count.
module usrp_tag_tx_scheduler
  import usrp_tag_sched_pkg::*;
#(
  parameter int unsigned CNT_WIDTH      = 24,
  parameter int unsigned NBITS_WIDTH    = 12,
  parameter int unsigned FRAME_WIDTH    = 16,
  parameter int unsigned TIMEOUT        = 2**20,
  parameter int unsigned DEF_SETTLE     = SCHED_DEF_SETTLE,
  parameter int unsigned DEF_PRMB_NBITS = SCHED_DEF_PRMB_NBITS,
  parameter int unsigned DEF_PRMB_OS    = SCHED_DEF_PRMB_OS,
  parameter int unsigned DEF_GAP        = SCHED_DEF_GAP
) (
  input  logic                   clk,
  input  logic                   reset,
  usrp_tag_tx_scheduler_if.slave cfg,
  input  logic                   cmd_start,
  input  logic                   cmd_stop,
  input  logic                   ext_trig,
  input  logic                   sync_ready,
  output logic [NBITS_WIDTH-1:0] prmb_idx,
  output logic                   prmb_active,
  output logic                   sig_srst,
  output logic                   tx_valid,
  output logic                   gpio_mark,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   timeout_err,
  output logic [FRAME_WIDTH-1:0] frame_cnt,
  output logic [2:0]             state_dbg
);

  localparam int unsigned TO_W    = $clog2(TIMEOUT + 1);
  localparam int unsigned FCMP_W  = FRAME_WIDTH + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic                   trig_en_live, sh_trig_en, shadow_ld, last_frame;
  logic [CNT_WIDTH-1:0]   sh_settle, sh_os, sh_gap;
  logic [NBITS_WIDTH-1:0] sh_nbits;
  logic [FRAME_WIDTH-1:0] sh_nframes;

  sched_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [NBITS_WIDTH-1:0] bit_q, bit_d;
  logic [TO_W-1:0]        to_q, to_d;
  logic [FRAME_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic                   timeout_q, timeout_d;
  logic                   frame_done_q, frame_done_d;
  logic                   trig_prev_q;
  logic                   tx_valid_q, sig_srst_q, prmb_active_q, busy_q;

  usrp_tag_sched_regs #(
    .CNT_WIDTH      (CNT_WIDTH),
    .NBITS_WIDTH    (NBITS_WIDTH),
    .FRAME_WIDTH    (FRAME_WIDTH),
    .DEF_SETTLE     (DEF_SETTLE),
    .DEF_PRMB_NBITS (DEF_PRMB_NBITS),
    .DEF_PRMB_OS    (DEF_PRMB_OS),
    .DEF_GAP        (DEF_GAP)
  ) u_regs (
    .clk          (clk),
    .reset        (reset),
    .cfg          (cfg),
    .shadow_ld    (shadow_ld),
    .trig_en_live (trig_en_live),
    .sh_settle    (sh_settle),
    .sh_nbits     (sh_nbits),
    .sh_os        (sh_os),
    .sh_gap       (sh_gap),
    .sh_nframes   (sh_nframes),
    .sh_trig_en   (sh_trig_en)
  );

  // A zero length still occupies one cycle.
  function automatic logic [CNT_WIDTH-1:0] last_cnt(input logic [CNT_WIDTH-1:0] len);
    return (len == '0) ? '0 : len - CNT_WIDTH'(1);
  endfunction

  assign shadow_ld  = (state_d == ST_SETTLE) && (state_q != ST_SETTLE);
  assign last_frame = (sh_nframes != '0) &&
                      (({1'b0, frame_cnt_q} + FCMP_W'(1)) == {1'b0, sh_nframes});

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    to_d         = to_q;
    frame_cnt_d  = frame_cnt_q;
    timeout_d    = timeout_q;
    frame_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          state_d     = trig_en_live ? ST_ARM : ST_SETTLE;
          frame_cnt_d = '0;
          timeout_d   = 1'b0;
          cnt_d       = '0;
        end
      end
      ST_ARM: begin
        cnt_d = '0;
        if (ext_trig && !trig_prev_q) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == last_cnt(sh_settle)) begin
          cnt_d   = '0;
          state_d = (sh_nbits == '0) ? ST_GAP : ST_PREAMBLE;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      // cnt_q is the oversample phase nested inside the bit index.
      ST_PREAMBLE: begin
        if (cnt_q == last_cnt(sh_os)) begin
          cnt_d = '0;
          if (bit_q == sh_nbits - NBITS_WIDTH'(1)) state_d = ST_GAP;
          else                                      bit_d   = bit_q + NBITS_WIDTH'(1);
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == last_cnt(sh_gap)) begin
          cnt_d   = '0;
          to_d    = '0;
          state_d = ST_TX;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_TX: begin
        if (sync_ready) begin
          frame_done_d = 1'b1;
          frame_cnt_d  = (&frame_cnt_q) ? frame_cnt_q : frame_cnt_q + FRAME_WIDTH'(1);
          cnt_d        = '0;
          if (last_frame)      state_d = ST_IDLE;
          else if (sh_trig_en) state_d = ST_ARM;
          else                 state_d = ST_SETTLE;
        end else if (to_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cmd_stop) begin
      state_d      = ST_IDLE;
      cnt_d        = '0;
      frame_done_d = 1'b0;
      frame_cnt_d  = frame_cnt_q;
      timeout_d    = timeout_q;
    end

    if (state_d != ST_PREAMBLE) bit_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      to_q          <= '0;
      frame_cnt_q   <= '0;
      timeout_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      trig_prev_q   <= 1'b0;
      tx_valid_q    <= 1'b0;
      sig_srst_q    <= 1'b0;
      prmb_active_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      to_q          <= to_d;
      frame_cnt_q   <= frame_cnt_d;
      timeout_q     <= timeout_d;
      frame_done_q  <= frame_done_d;
      trig_prev_q   <= ext_trig;
      tx_valid_q    <= (state_d == ST_SETTLE) || (state_d == ST_PREAMBLE) || (state_d == ST_TX);
      sig_srst_q    <= (state_d == ST_GAP);
      prmb_active_q <= (state_d == ST_PREAMBLE);
      busy_q        <= (state_d != ST_IDLE);
    end
  end

  assign prmb_idx    = bit_q;
  assign prmb_active = prmb_active_q;
  assign gpio_mark   = prmb_active_q;
  assign sig_srst    = sig_srst_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_q;
  assign frame_cnt   = frame_cnt_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_usrp_tag_tx_scheduler.sv
// Directed bench for the transmit scheduler: a per-cycle vector table for one
// default frame plus hand-written multi-cycle scenarios.
module tb_usrp_tag_tx_scheduler;

  localparam int S_IDLE = 0, S_ARM = 1, S_SETTLE = 2, S_PRMB = 3, S_GAP = 4, S_TX = 5;

  logic        clk, reset;
  logic        cmd_start, cmd_stop, ext_trig, sync_ready;
  logic [11:0] prmb_idx;
  logic        prmb_active, sig_srst, tx_valid, gpio_mark, busy, frame_done, timeout_err;
  logic [15:0] frame_cnt;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  usrp_tag_tx_scheduler_if cfg_bus ();

  usrp_tag_tx_scheduler #(
    .TIMEOUT        (64),
    .DEF_SETTLE     (4),
    .DEF_PRMB_NBITS (3),
    .DEF_PRMB_OS    (2),
    .DEF_GAP        (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg         (cfg_bus),
    .cmd_start   (cmd_start),
    .cmd_stop    (cmd_stop),
    .ext_trig    (ext_trig),
    .sync_ready  (sync_ready),
    .prmb_idx    (prmb_idx),
    .prmb_active (prmb_active),
    .sig_srst    (sig_srst),
    .tx_valid    (tx_valid),
    .gpio_mark   (gpio_mark),
    .busy        (busy),
    .frame_done  (frame_done),
    .timeout_err (timeout_err),
    .frame_cnt   (frame_cnt),
    .state_dbg   (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic start;
    logic sync;
    int   st;
    logic txv;
    logic srst;
    logic pact;
    int   idx;
    logic bsy;
    logic fdone;
    int   fcnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(logic start, logic sync, int st, logic txv, logic srst,
                               logic pact, int idx, logic bsy, logic fdone, int fcnt);
    vec_t v;
    v.start = start; v.sync = sync; v.st = st; v.txv = txv; v.srst = srst;
    v.pact = pact; v.idx = idx; v.bsy = bsy; v.fdone = fdone; v.fcnt = fcnt;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic [31:0] data);
    cfg_bus.cfg_wr   = 1'b1;
    cfg_bus.cfg_addr = addr;
    cfg_bus.cfg_data = data;
    tick();
    cfg_bus.cfg_wr   = 1'b0;
  endtask

  task automatic pulse_start();
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic pulse_stop();
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
  endtask

  task automatic pulse_sync();
    sync_ready = 1'b1;
    tick();
    sync_ready = 1'b0;
  endtask

  task automatic wait_state(input int st, input int budget, input string name);
    int n = 0;
    while (int'(state_dbg) != st && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(state_dbg), 32'(st));
  endtask

  task automatic count_state(input int st, output int n);
    n = 0;
    while (int'(state_dbg) == st && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".state"}, 32'(state_dbg), S_IDLE);
    chk({tag, ".tx_valid"}, 32'(tx_valid), 0);
    chk({tag, ".sig_srst"}, 32'(sig_srst), 0);
    chk({tag, ".prmb_active"}, 32'(prmb_active), 0);
    chk({tag, ".gpio_mark"}, 32'(gpio_mark), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".frame_done"}, 32'(frame_done), 0);
    chk({tag, ".prmb_idx"}, 32'(prmb_idx), 0);
  endtask

  initial begin
    int n;
    int zexp[6];
    logic saw_pact;

    reset = 1'b1; cmd_start = 1'b0; cmd_stop = 1'b0; ext_trig = 1'b0; sync_ready = 1'b0;
    cfg_bus.cfg_wr = 1'b0; cfg_bus.cfg_addr = '0; cfg_bus.cfg_data = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk_quiet("reset");
    chk("reset.timeout_err", 32'(timeout_err), 0);
    chk("reset.frame_cnt", 32'(frame_cnt), 0);

    // One default frame: settle 4, preamble 3 bits x os 2, gap 5, TX 2 cycles then sync.
    vecs.push_back(mkv(1, 0, S_SETTLE, 1, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mkv(0, 0, S_SETTLE, 1, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 6; i++) vecs.push_back(mkv(0, 0, S_PRMB, 1, 0, 1, i / 2, 1, 0, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mkv(0, 0, S_GAP, 0, 1, 0, 0, 1, 0, 0));
    for (int i = 0; i < 2; i++) vecs.push_back(mkv(0, 0, S_TX, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 1, S_IDLE, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mkv(0, 0, S_IDLE, 0, 0, 0, 0, 0, 0, 1));

    foreach (vecs[i]) begin
      cmd_start  = vecs[i].start;
      sync_ready = vecs[i].sync;
      tick();
      chk($sformatf("row%0d.state", i), 32'(state_dbg), 32'(vecs[i].st));
      chk($sformatf("row%0d.tx_valid", i), 32'(tx_valid), 32'(vecs[i].txv));
      chk($sformatf("row%0d.sig_srst", i), 32'(sig_srst), 32'(vecs[i].srst));
      chk($sformatf("row%0d.prmb_active", i), 32'(prmb_active), 32'(vecs[i].pact));
      chk($sformatf("row%0d.gpio_mark", i), 32'(gpio_mark), 32'(vecs[i].pact));
      chk($sformatf("row%0d.prmb_idx", i), 32'(prmb_idx), 32'(vecs[i].idx));
      chk($sformatf("row%0d.busy", i), 32'(busy), 32'(vecs[i].bsy));
      chk($sformatf("row%0d.frame_done", i), 32'(frame_done), 32'(vecs[i].fdone));
      chk($sformatf("row%0d.frame_cnt", i), 32'(frame_cnt), 32'(vecs[i].fcnt));
    end
    cmd_start = 1'b0; sync_ready = 1'b0;

    // Three back-to-back frames, sync_ready on the 10th TX cycle.
    cfg_write(3'd4, 32'd3);
    pulse_start();
    for (int f = 1; f <= 3; f++) begin
      wait_state(S_TX, 60, $sformatf("nf3.f%0d.reach_tx", f));
      repeat (9) tick();
      chk($sformatf("nf3.f%0d.still_tx", f), 32'(state_dbg), S_TX);
      pulse_sync();
      chk($sformatf("nf3.f%0d.frame_done", f), 32'(frame_done), 1);
      chk($sformatf("nf3.f%0d.frame_cnt", f), 32'(frame_cnt), 32'(f));
      chk($sformatf("nf3.f%0d.next", f), 32'(state_dbg), (f < 3) ? S_SETTLE : S_IDLE);
    end
    tick();
    chk("nf3.busy_after", 32'(busy), 0);

    // Run-forever, stopped in the middle of the second preamble.
    cfg_write(3'd4, 32'd0);
    pulse_start();
    wait_state(S_TX, 60, "nf0.reach_tx");
    pulse_sync();
    chk("nf0.frame_done", 32'(frame_done), 1);
    chk("nf0.restart", 32'(state_dbg), S_SETTLE);
    wait_state(S_PRMB, 30, "nf0.reach_prmb");
    tick();
    pulse_stop();
    chk_quiet("stop");
    tick();
    chk("stop.no_frame_done", 32'(frame_done), 0);

    // Trigger arming: held-high level must not fire, a fresh edge must.
    cfg_write(3'd5, 32'd1);
    ext_trig = 1'b1;
    repeat (2) tick();
    pulse_start();
    chk("trig.arm", 32'(state_dbg), S_ARM);
    repeat (4) tick();
    chk("trig.level_hold", 32'(state_dbg), S_ARM);
    ext_trig = 1'b0;
    tick();
    chk("trig.low", 32'(state_dbg), S_ARM);
    ext_trig = 1'b1;
    tick();
    chk("trig.edge", 32'(state_dbg), S_SETTLE);
    ext_trig = 1'b0;
    pulse_stop();
    chk("trig.stop", 32'(state_dbg), S_IDLE);
    cfg_write(3'd5, 32'd0);

    // gap_len written during frame 1 preamble applies from frame 2.
    cfg_write(3'd4, 32'd2);
    pulse_start();
    wait_state(S_PRMB, 30, "gapw.reach_prmb");
    cfg_write(3'd3, 32'd9);
    wait_state(S_GAP, 30, "gapw.reach_gap1");
    count_state(S_GAP, n);
    chk("gapw.frame1_gap", 32'(n), 5);
    pulse_sync();
    wait_state(S_GAP, 60, "gapw.reach_gap2");
    count_state(S_GAP, n);
    chk("gapw.frame2_gap", 32'(n), 9);
    pulse_sync();
    chk("gapw.done_state", 32'(state_dbg), S_IDLE);
    chk("gapw.frame_cnt", 32'(frame_cnt), 2);

    // TX timeout without sync_ready.
    cfg_write(3'd4, 32'd1);
    pulse_start();
    wait_state(S_TX, 80, "tmo.reach_tx");
    count_state(S_TX, n);
    chk("tmo.tx_cycles", 32'(n), 64);
    chk("tmo.state", 32'(state_dbg), S_IDLE);
    chk("tmo.timeout_err", 32'(timeout_err), 1);
    chk("tmo.frame_done", 32'(frame_done), 0);
    chk("tmo.frame_cnt", 32'(frame_cnt), 0);
    chk("tmo.tx_valid", 32'(tx_valid), 0);
    pulse_start();
    chk("tmo.cleared", 32'(timeout_err), 0);
    chk("tmo.restart", 32'(state_dbg), S_SETTLE);
    pulse_stop();

    // Zero preamble/os/gap: SETTLE straight into a single GAP cycle.
    cfg_write(3'd1, 32'd0);
    cfg_write(3'd2, 32'd0);
    cfg_write(3'd3, 32'd0);
    zexp = '{S_SETTLE, S_SETTLE, S_SETTLE, S_SETTLE, S_GAP, S_TX};
    saw_pact = 1'b0;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("zero.seq%0d", i), 32'(state_dbg), 32'(zexp[i]));
      saw_pact = saw_pact | prmb_active;
      if (i < 5) tick();
    end
    chk("zero.no_prmb_active", 32'(saw_pact), 0);

    // Reset mid-TX, then a frame must follow the power-on schedule again.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_quiet("rst_tx");
    chk("rst_tx.timeout_err", 32'(timeout_err), 0);
    tick();
    pulse_start();
    count_state(S_SETTLE, n);
    chk("rst_def.settle", 32'(n), 4);
    count_state(S_PRMB, n);
    chk("rst_def.preamble", 32'(n), 6);
    count_state(S_GAP, n);
    chk("rst_def.gap", 32'(n), 5);
    chk("rst_def.tx", 32'(state_dbg), S_TX);
    pulse_sync();
    chk("rst_def.idle", 32'(state_dbg), S_IDLE);
    chk("rst_def.frame_cnt", 32'(frame_cnt), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usrp_tag_tx_scheduler.md
Name: usrp_tag_tx_scheduler

Overview:
Runtime-configurable frame sequencer for the tag-chip transmit path. It replaces fixed-parameter sequencing with a settings-bus-programmed schedule: settle, BPSK preamble, gap, then a localization burst. It drives the preamble bit index, the signal-generator soft reset, tx_valid and the GPIO sync marker. It sits between the host settings bus / front-panel GPIO and the preamble ROM plus the mtx signal generator.

Parameters:
CNT_WIDTH, 24, width of every length and config counter
NBITS_WIDTH, 12, width of preamble bit index and bit count
FRAME_WIDTH, 16, width of frame counter and frame-count register
TIMEOUT, 2**20, max cycles in TX waiting for sync_ready
DEF_SETTLE, 32, reset value of settle_len
DEF_PRMB_NBITS, 2046, reset value of prmb_nbits
DEF_PRMB_OS, 256, reset value of prmb_os
DEF_GAP, 32768, reset value of gap_len

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
cfg_wr  in  1  settings write strobe
cfg_addr  in  3  register address
cfg_data  in  32  write data, LSB-aligned
cmd_start  in  1  start-schedule pulse
cmd_stop  in  1  abort pulse
ext_trig  in  1  external trigger, already synchronised to clk
sync_ready  in  1  end-of-burst flag from signal generator
prmb_idx  out  NBITS_WIDTH  preamble bit index to ROM
prmb_active  out  1  selects preamble onto IQ mux
sig_srst  out  1  soft reset to signal generator
tx_valid  out  1  output sample valid
gpio_mark  out  1  sync marker, high during PREAMBLE
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse at end of each frame
timeout_err  out  1  sticky; cleared by cmd_start or reset
frame_cnt  out  FRAME_WIDTH  completed frames since start
state_dbg  out  3  current state encoding

Behaviour:
- All outputs registered. Reset: state IDLE; all outputs 0; config registers take their DEF_* values; nframes=1; trig_en=0.
- Registers: 0 settle_len, 1 prmb_nbits, 2 prmb_os, 3 gap_len, 4 nframes (0 = run forever), 5 ctrl[0] trig_en. Addresses 6–7 are ignored. Writes land immediately in the live registers.
- Shadow copies latch the live registers on entry to SETTLE. Mid-frame writes therefore take effect at the next frame.
- States:
  - IDLE=0: cmd_start -> ARM if trig_en, else SETTLE. Clears frame_cnt and timeout_err.
  - ARM=1: waits for a rising edge of ext_trig -> SETTLE. A level already high on entry does not fire.
  - SETTLE=2: lasts max(settle_len,1) cycles -> PREAMBLE. If prmb_nbits==0 it goes straight to GAP.
  - PREAMBLE=3: lasts prmb_nbits * max(prmb_os,1) cycles. prmb_idx starts at 0 and increments every os cycles. On the last cycle prmb_idx==nbits-1 -> GAP.
  - GAP=4: sig_srst=1 for max(gap_len,1) cycles. tx_valid=0 -> TX.
  - TX=5: tx_valid=1, sig_srst=0. sync_ready -> frame end. If TIMEOUT cycles elapse without sync_ready: timeout_err=1 -> IDLE.
- Frame end: frame_done pulses and frame_cnt increments, saturating at all-ones. Then, if nframes!=0 and frame_cnt+1==nframes -> IDLE; otherwise -> ARM/SETTLE per the shadow trig_en.
- tx_valid=1 in SETTLE, PREAMBLE and TX; 0 in IDLE, ARM and GAP.
- prmb_active = gpio_mark = (state==PREAMBLE). prmb_idx resets to 0 on leaving PREAMBLE.
- cmd_stop in any state -> IDLE next cycle, all outputs deasserted, no frame_done. cmd_stop together with cmd_start: stop wins.
- cmd_start while busy is ignored.
- sync_ready outside TX is ignored.
- cfg_wr together with a shadow latch: the shadow takes the old value.
- Length arithmetic is unsigned CNT_WIDTH. Counters compare against length-1; there is no multiply, because the bit index and os counter are nested.

Decomposition:
- Package usrp_tag_sched_pkg: state encodings, register address constants, DEF_* defaults.
- Sub-module usrp_tag_sched_regs: settings decode, live registers and shadow latch.
- The FSM and counters stay in the top level.

Test Plan:
- Defaults reduced to settle=4, nbits=3, os=2, gap=5; cmd_start at t0 -> SETTLE for 4 cycles; prmb_idx sequence 0,0,1,1,2,2; sig_srst high for 5 cycles; TX until sync_ready; frame_done once; busy drops; frame_cnt=1.
- nframes=3, sync_ready 10 cycles into each TX -> three back-to-back frames, frame_cnt 1,2,3, then IDLE. nframes=0 -> runs until cmd_stop; stop mid-PREAMBLE -> IDLE next cycle, no frame_done.
- trig_en=1 with ext_trig held high before start -> stays in ARM; low-then-high -> SETTLE on the cycle after the edge.
- Write gap_len=9 during PREAMBLE of frame 1 -> frame 1 gap is still 5 cycles; frame 2 gap is 9 cycles.
- sync_ready never asserted, TIMEOUT=64 -> exactly 64 TX cycles, then timeout_err=1 and IDLE; next cmd_start clears the flag.
- prmb_nbits=0, os=0, gap=0 -> SETTLE to GAP of 1 cycle, then TX; prmb_active never asserts; reset asserted mid-TX -> all outputs 0 and registers return to defaults.
